// File: rtl/axi_apb_pkg.sv
// Shared FSM, grant and response encodings for the AXI4-Lite
// to APB request arbiter.
package axi_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } gnt_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [1:0] cpl_resp(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_apb_rw_arbiter_if.sv
// AXI4-Lite slave channels plus the request/completion handshake
// towards the APB sequencer.
interface axi_apb_rw_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] s_axi_awaddr;
   logic              s_axi_awvalid;
   logic              s_axi_awready;
   logic [DATA_W-1:0] s_axi_wdata;
   logic [STRB_W-1:0] s_axi_wstrb;
   logic              s_axi_wvalid;
   logic              s_axi_wready;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bvalid;
   logic              s_axi_bready;
   logic [ADDR_W-1:0] s_axi_araddr;
   logic              s_axi_arvalid;
   logic              s_axi_arready;
   logic [DATA_W-1:0] s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid;
   logic              s_axi_rready;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;
   logic              cpl_valid;
   logic [DATA_W-1:0] cpl_rdata;
   logic              cpl_err;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_rready,
      output req_valid, req_write, req_addr,
      output req_wdata, req_wstrb,
      input  req_ready,
      input  cpl_valid, cpl_rdata, cpl_err
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_rready,
      input  req_valid, req_write, req_addr,
      input  req_wdata, req_wstrb,
      output req_ready,
      output cpl_valid, cpl_rdata, cpl_err
   );

endinterface

// File: rtl/axi_apb_rr_arb.sv
// Two-way read/write round-robin arbiter; write wins the first
// contested decision after reset.
module axi_apb_rr_arb
   import axi_apb_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic wr_req_i,
   input  logic rd_req_i,
   input  logic take_i,
   output logic gnt_valid_o,
   output gnt_e gnt_o
);

   gnt_e last_q, last_d;
   logic both;

   assign both        = wr_req_i & rd_req_i;
   assign gnt_valid_o = wr_req_i | rd_req_i;

   always_comb begin
      gnt_o = GNT_WR;
      if (both) begin
         gnt_o = (last_q == GNT_RD) ? GNT_WR : GNT_RD;
      end else if (rd_req_i) begin
         gnt_o = GNT_RD;
      end
   end

   // Only contested decisions move the fairness pointer
   always_comb begin
      last_d = last_q;
      if (take_i && both) begin
         last_d = gnt_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q <= GNT_RD;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/axi_apb_rw_arbiter.sv
// AXI4-Lite slave front end: buffers AW/W/AR, arbitrates read vs
// write and issues one transaction at a time to the APB sequencer.
module axi_apb_rw_arbiter
   import axi_apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic                 s_axi_clk,
   input logic                 s_axi_aresetn,
   axi_apb_rw_arbiter_if.slave bus
);

   localparam int STRB_W = DATA_W / 8;

   logic              aw_full_q, aw_full_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic              w_full_q, w_full_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;
   logic              ar_full_q, ar_full_d;
   logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;

   state_e            state_q, state_d;
   gnt_e              gnt_q, gnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        resp_q, resp_d;

   logic aw_rdy, w_rdy, ar_rdy;
   logic aw_hs, w_hs, ar_hs;
   logic free_wr, free_rd, take;
   logic arb_valid;
   gnt_e arb_gnt;
   logic is_wr, issue, in_resp, resp_done;

   assign aw_rdy = s_axi_aresetn & ~aw_full_q;
   assign w_rdy  = s_axi_aresetn & ~w_full_q;
   assign ar_rdy = s_axi_aresetn & ~ar_full_q;
   assign aw_hs  = bus.s_axi_awvalid & aw_rdy;
   assign w_hs   = bus.s_axi_wvalid & w_rdy;
   assign ar_hs  = bus.s_axi_arvalid & ar_rdy;

   axi_apb_rr_arb u_arb (
      .clk_i       (s_axi_clk),
      .rst_ni      (s_axi_aresetn),
      .wr_req_i    (aw_full_q & w_full_q),
      .rd_req_i    (ar_full_q),
      .take_i      (take),
      .gnt_valid_o (arb_valid),
      .gnt_o       (arb_gnt)
   );

   // Fill and free never coincide: fill needs empty, free needs full
   always_comb begin
      aw_full_d = aw_full_q;
      aw_addr_d = aw_addr_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      ar_full_d = ar_full_q;
      ar_addr_d = ar_addr_q;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_addr_d = bus.s_axi_awaddr;
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = bus.s_axi_wdata;
         w_strb_d = bus.s_axi_wstrb;
      end
      if (ar_hs) begin
         ar_full_d = 1'b1;
         ar_addr_d = bus.s_axi_araddr;
      end
      if (free_wr) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
      end
      if (free_rd) begin
         ar_full_d = 1'b0;
      end
   end

   assign is_wr     = (gnt_q == GNT_WR);
   assign resp_done = is_wr ? bus.s_axi_bready : bus.s_axi_rready;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rdata_d = rdata_q;
      resp_d  = resp_q;
      take    = 1'b0;
      free_wr = 1'b0;
      free_rd = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               take    = 1'b1;
               gnt_d   = arb_gnt;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.cpl_valid) begin
               resp_d  = cpl_resp(bus.cpl_err);
               state_d = ST_RESP;
               if (is_wr) begin
                  free_wr = 1'b1;
               end else begin
                  free_rd = 1'b1;
                  rdata_d = bus.cpl_rdata;
               end
            end
         end
         ST_RESP: begin
            if (resp_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_clk) begin
      if (!s_axi_aresetn) begin
         state_q   <= ST_IDLE;
         gnt_q     <= GNT_WR;
         aw_full_q <= 1'b0;
         aw_addr_q <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         ar_full_q <= 1'b0;
         ar_addr_q <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         ar_full_q <= ar_full_d;
         ar_addr_q <= ar_addr_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   // Outputs are masked by reset so they are quiet before the first edge
   assign issue   = s_axi_aresetn & (state_q == ST_ISSUE);
   assign in_resp = s_axi_aresetn & (state_q == ST_RESP);

   assign bus.s_axi_awready = aw_rdy;
   assign bus.s_axi_wready  = w_rdy;
   assign bus.s_axi_arready = ar_rdy;

   assign bus.req_valid = issue;
   assign bus.req_write = issue & is_wr;
   assign bus.req_addr  = !issue ? '0 : (is_wr ? aw_addr_q : ar_addr_q);
   assign bus.req_wdata = (issue & is_wr) ? w_data_q : '0;
   assign bus.req_wstrb = (issue & is_wr) ? w_strb_q : '0;

   assign bus.s_axi_bvalid = in_resp & is_wr;
   assign bus.s_axi_rvalid = in_resp & ~is_wr;
   assign bus.s_axi_bresp  = s_axi_aresetn ? resp_q : RESP_OKAY;
   assign bus.s_axi_rresp  = s_axi_aresetn ? resp_q : RESP_OKAY;
   assign bus.s_axi_rdata  = s_axi_aresetn ? rdata_q : '0;

endmodule

// File: tb/tb_axi_apb_rw_arbiter.sv
// Scoreboard bench: expected requests/responses are queued at issue
// and popped by independent sequencer and B/R monitor processes.
module tb_axi_apb_rw_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
   } wr_t;

   typedef struct packed {
      logic          err;
      logic [DW-1:0] rdata;
   } cpl_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axi_apb_rw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   axi_apb_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .s_axi_clk     (clk),
      .s_axi_aresetn (rstn),
      .bus           (bus)
   );

   int n_tests = 0;
   int n_fail = 0;

   wr_t           wr_exp[$];
   logic [AW-1:0] rd_exp[$];
   logic [1:0]    b_exp[$];
   logic [DW+1:0] r_exp[$];
   cpl_t          plan[$];
   logic          issue_log[$];

   bit no_cpl = 0;
   bit b_hold = 0;
   int n_issued = 0;
   int n_b = 0;
   int n_r = 0;
   int n_aband = 0;
   int stray_req = 0;
   int stray_done = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out or unexpected event", name);
   endtask

   task automatic send_aw(input logic [AW-1:0] a);
      bus.s_axi_awaddr  = a;
      bus.s_axi_awvalid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.s_axi_awready) begin
            @(posedge clk);
            #1 bus.s_axi_awvalid = 1'b0;
            return;
         end
      end
      bus.s_axi_awvalid = 1'b0;
      fail("aw_timeout");
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
      bus.s_axi_wdata  = d;
      bus.s_axi_wstrb  = s;
      bus.s_axi_wvalid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.s_axi_wready) begin
            @(posedge clk);
            #1 bus.s_axi_wvalid = 1'b0;
            return;
         end
      end
      bus.s_axi_wvalid = 1'b0;
      fail("w_timeout");
   endtask

   task automatic send_ar(input logic [AW-1:0] a);
      bus.s_axi_araddr  = a;
      bus.s_axi_arvalid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.s_axi_arready) begin
            @(posedge clk);
            #1 bus.s_axi_arvalid = 1'b0;
            return;
         end
      end
      bus.s_axi_arvalid = 1'b0;
      fail("ar_timeout");
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int aw_gap,
                        input int w_gap);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.strb = s;
      wr_exp.push_back(w);
      fork
         begin
            repeat (aw_gap) begin @(posedge clk); #1; end
            send_aw(a);
         end
         begin
            repeat (w_gap) begin @(posedge clk); #1; end
            send_w(d, s);
         end
      join
   endtask

   task automatic read(input logic [AW-1:0] a);
      rd_exp.push_back(a);
      send_ar(a);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (wr_exp.size() == 0 && rd_exp.size() == 0 &&
             b_exp.size() == 0 && r_exp.size() == 0 &&
             !bus.s_axi_bvalid && !bus.s_axi_rvalid && !bus.req_valid &&
             (n_issued - n_b - n_r - n_aband) == 0) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      fail(name);
   endtask

   // Sequencer model: accepts requests, checks them, answers with a pulse
   initial begin : responder
      cpl_t c;
      wr_t  w;
      logic was_wr;
      int   d;
      bus.req_ready = 1'b0;
      bus.cpl_valid = 1'b0;
      bus.cpl_rdata = '0;
      bus.cpl_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (stray_req != stray_done) begin
            stray_done++;
            @(posedge clk);
            #1;
            bus.cpl_valid = 1'b1;
            bus.cpl_err   = 1'b1;
            bus.cpl_rdata = 32'h0BAD_0BAD;
            @(posedge clk);
            #1;
            bus.cpl_valid = 1'b0;
            bus.cpl_err   = 1'b0;
            bus.cpl_rdata = '0;
         end else if (rstn && bus.req_valid && $urandom_range(3) != 0) begin
            check("one_outstanding", n_issued - n_b - n_r - n_aband, 0);
            was_wr = bus.req_write;
            issue_log.push_back(was_wr);
            if (was_wr) begin
               if (wr_exp.size() == 0) fail("unexpected_write_req");
               else begin
                  w = wr_exp.pop_front();
                  check("req_addr_wr", bus.req_addr, w.addr);
                  check("req_wdata", bus.req_wdata, w.data);
                  check("req_wstrb", bus.req_wstrb, w.strb);
               end
            end else begin
               if (rd_exp.size() == 0) fail("unexpected_read_req");
               else begin
                  check("req_addr_rd", bus.req_addr, rd_exp.pop_front());
                  check("req_wdata_rd", bus.req_wdata, 0);
                  check("req_wstrb_rd", bus.req_wstrb, 0);
               end
            end
            if (plan.size() != 0) c = plan.pop_front();
            else begin
               c.err   = 1'($urandom_range(1));
               c.rdata = 32'($urandom);
            end
            bus.req_ready = 1'b1;
            n_issued++;
            @(posedge clk);
            #1 bus.req_ready = 1'b0;
            if (!no_cpl) begin
               d = $urandom_range(3);
               repeat (d) begin @(posedge clk); #1; end
               if (was_wr) b_exp.push_back(c.err ? 2'b10 : 2'b00);
               else r_exp.push_back({c.rdata, (c.err ? 2'b10 : 2'b00)});
               bus.cpl_valid = 1'b1;
               bus.cpl_rdata = c.rdata;
               bus.cpl_err   = c.err;
               @(posedge clk);
               #1;
               bus.cpl_valid = 1'b0;
               bus.cpl_rdata = '0;
               bus.cpl_err   = 1'b0;
            end
         end
      end
   end

   initial begin : b_mon
      bus.s_axi_bready = 1'b0;
      forever begin
         @(negedge clk);
         bus.s_axi_bready = !b_hold && ($urandom_range(2) != 0);
         if (rstn && bus.s_axi_bvalid && bus.s_axi_bready) begin
            n_b++;
            if (b_exp.size() == 0) fail("unexpected_b");
            else check("bresp", bus.s_axi_bresp, b_exp.pop_front());
         end
      end
   end

   initial begin : r_mon
      bus.s_axi_rready = 1'b0;
      forever begin
         @(negedge clk);
         bus.s_axi_rready = ($urandom_range(2) != 0);
         if (rstn && bus.s_axi_rvalid && bus.s_axi_rready) begin
            n_r++;
            if (r_exp.size() == 0) fail("unexpected_r");
            else check("rdata_rresp", {bus.s_axi_rdata, bus.s_axi_rresp},
                       r_exp.pop_front());
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit         seen;
      int         n0, nb0, nr0;
      logic [1:0] held;
      logic       g0, g1, g2, g3;
      bus.s_axi_awaddr  = '0;
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata   = '0;
      bus.s_axi_wstrb   = '0;
      bus.s_axi_wvalid  = 1'b0;
      bus.s_axi_araddr  = '0;
      bus.s_axi_arvalid = 1'b0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", bus.s_axi_awready, 0);
      check("rst_wready", bus.s_axi_wready, 0);
      check("rst_arready", bus.s_axi_arready, 0);
      check("rst_bvalid", bus.s_axi_bvalid, 0);
      check("rst_rvalid", bus.s_axi_rvalid, 0);
      check("rst_req_valid", bus.req_valid, 0);
      check("rst_rdata", bus.s_axi_rdata, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("idle_awready", bus.s_axi_awready, 1);
      check("idle_wready", bus.s_axi_wready, 1);
      check("idle_arready", bus.s_axi_arready, 1);
      check("idle_req_valid", bus.req_valid, 0);
      @(posedge clk);
      #1;

      // AW at cycle 0, W three cycles later, OKAY completion
      plan.push_back(cpl_t'{err: 1'b0, rdata: 32'h1234_5678});
      write(32'h10, 32'hA5A5_A5A5, 4'hF, 0, 3);
      wait_idle("single_write_idle");
      check("single_write_bcount", n_b, 1);

      // Simultaneous pairs: write first after reset, then read first
      issue_log.delete();
      fork
         write(32'h100, 32'h1111_0000, 4'h3, 0, 0);
         read(32'h200);
      join
      wait_idle("rr_pair1_idle");
      fork
         write(32'h104, 32'h2222_0000, 4'hC, 0, 0);
         read(32'h204);
      join
      wait_idle("rr_pair2_idle");
      check("rr_log_size", issue_log.size(), 4);
      if (issue_log.size() >= 4) begin
         g0 = issue_log[0];
         g1 = issue_log[1];
         g2 = issue_log[2];
         g3 = issue_log[3];
         check("rr_pair1_first_write", g0, 1);
         check("rr_pair1_second_read", g1, 0);
         check("rr_pair2_first_read", g2, 0);
         check("rr_pair2_second_write", g3, 1);
      end

      // Read with error completion
      plan.push_back(cpl_t'{err: 1'b1, rdata: 32'hDEAD_BEEF});
      read(32'h20);
      wait_idle("read_err_idle");

      // B held off: response stable, AR accepted but not issued
      b_hold = 1'b1;
      plan.push_back(cpl_t'{err: 1'b1, rdata: 32'h0});
      write(32'h30, 32'hCAFE_F00D, 4'hC, 1, 0);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = bus.s_axi_bvalid;
      end
      check("bstall_bvalid_seen", seen, 1);
      held = bus.s_axi_bresp;
      check("bstall_bresp", held, 2);
      @(posedge clk);
      #1;
      fork
         read(32'h40);
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bstall_bvalid_hold", bus.s_axi_bvalid, 1);
            check("bstall_bresp_hold", bus.s_axi_bresp, held);
            check("bstall_no_req", bus.req_valid, 0);
         end
      join
      check("bstall_ar_taken", bus.s_axi_arready, 0);
      @(posedge clk);
      #1 b_hold = 1'b0;
      wait_idle("bstall_idle");

      // Reset while waiting for completion abandons the write
      no_cpl = 1'b1;
      n0 = n_issued;
      write(32'h50, 32'h5555_AAAA, 4'hF, 0, 0);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = (n_issued != n0);
      end
      check("rstwait_issued", seen, 1);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      check("rstwait_rst_awready", bus.s_axi_awready, 0);
      check("rstwait_rst_bvalid", bus.s_axi_bvalid, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      n_aband++;
      @(negedge clk);
      check("rstwait_req_valid", bus.req_valid, 0);
      check("rstwait_bvalid", bus.s_axi_bvalid, 0);
      check("rstwait_rvalid", bus.s_axi_rvalid, 0);
      check("rstwait_awready", bus.s_axi_awready, 1);
      check("rstwait_wready", bus.s_axi_wready, 1);
      stray_req++;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("stray_cpl_no_b", bus.s_axi_bvalid, 0);
         check("stray_cpl_no_r", bus.s_axi_rvalid, 0);
      end
      no_cpl = 1'b0;
      @(posedge clk);
      #1;

      // Concurrent random traffic
      nb0 = n_b;
      nr0 = n_r;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               write(32'($urandom), 32'($urandom), 4'($urandom_range(15)),
                     $urandom_range(3), $urandom_range(3));
               repeat ($urandom_range(4)) begin @(posedge clk); #1; end
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               read(32'($urandom) & 32'hFFFF_FFFC);
               repeat ($urandom_range(4)) begin @(posedge clk); #1; end
            end
         end
      join
      wait_idle("random_idle");
      check("random_b_count", n_b - nb0, 40);
      check("random_r_count", n_r - nr0, 40);
      check("plan_drained", plan.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_apb_rw_arbiter.md
AXI_APB_RW_ARBITER -- requirements
Module: axi_apb_rw_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; STRB_W = DATA_W/8.
REQ-003 SHALL have port s_axi_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port s_axi_aresetn, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have ports s_axi_awaddr/awvalid/awready and s_axi_araddr/arvalid/arready: in ADDR_W/in 1/out 1 each, AXI4-Lite address channels.
REQ-006 SHALL have ports s_axi_wdata/wstrb/wvalid/wready: in DATA_W/in STRB_W/in 1/out 1, write data channel.
REQ-007 SHALL have ports s_axi_bresp/bvalid/bready: out 2/out 1/in 1, write response.
REQ-008 SHALL have ports s_axi_rdata/rresp/rvalid/rready: out DATA_W/out 2/out 1/in 1, read response.
REQ-009 SHALL have ports req_valid/req_ready: out 1/in 1, transaction issue handshake to the APB sequencer.
REQ-010 SHALL have ports req_write/req_addr/req_wdata/req_wstrb: out 1/ADDR_W/DATA_W/STRB_W, issued transaction.
REQ-011 SHALL have ports cpl_valid/cpl_rdata/cpl_err: in 1/DATA_W/1, one-cycle completion pulse from the sequencer.

Function
REQ-012 SHALL hold AW, W and AR in three independent one-entry buffers; each xREADY is high exactly when its buffer is empty, and a buffer fills on the xVALID && xREADY cycle.
REQ-013 SHALL treat a write as pending only when both the AW and W buffers are full; AW and W arriving in any order or cycle SHALL be accepted.
REQ-014 SHALL treat a read as pending when the AR buffer is full.
REQ-015 SHALL run FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE with at most one transaction outstanding.
REQ-016 In IDLE, if any request is pending, SHALL grant one request and move to ISSUE on the next cycle.
REQ-017 When read and write are pending together, SHALL grant the type not granted last (round-robin); after reset, write wins first.
REQ-018 In ISSUE, SHALL drive req_valid=1 with the granted fields held stable; on req_ready SHALL move to WAIT.
REQ-019 For a read, SHALL drive req_wdata=0 and req_wstrb=0.
REQ-020 In WAIT, on cpl_valid SHALL register cpl_rdata (reads only) and the response code, free the granted buffers, and move to RESP.
REQ-021 SHALL set the response code to 2'b10 (SLVERR) if cpl_err is high, otherwise 2'b00 (OKAY).
REQ-022 In RESP, SHALL assert bvalid (write) or rvalid (read) with stable data until bready/rready, then return to IDLE.
REQ-023 Minimum latency SHALL be: buffer fill at cycle 0, ISSUE at cycle 1, WAIT at cycle 2 if req_ready is high, RESP valid the cycle after cpl_valid.
REQ-024 SHALL ignore cpl_valid outside WAIT.
REQ-025 Freed buffers SHALL accept new AW/W/AR from the cycle after the completion, so a new request overlaps RESP but is not granted before IDLE.
REQ-026 A buffer SHALL not be overwritten while full; a valid on a full buffer SHALL be stalled by its ready being low.

Reset
REQ-027 While s_axi_aresetn is 0 at a clock edge, SHALL go to IDLE, empty all buffers, and set last-grant to read.
REQ-028 During reset SHALL drive awready, wready and arready to 0, and SHALL drive all other outputs (bvalid, rvalid, req_valid, bresp, rresp, rdata, req_* fields) to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction with no response issued.

Structure
REQ-030 SHALL import the FSM state encoding, RESP_OKAY/RESP_SLVERR constants and the grant-type enum from shared package axi_apb_pkg.
REQ-031 SHALL place the two-way round-robin grant logic in sub-module axi_apb_rr_arb, instantiated once.

Verification
REQ-032 Write AW 0x10 in cycle 0, W 0xA5A5A5A5/strb 0xF in cycle 3 -> single req: write=1, addr=0x10, wdata=0xA5A5A5A5; cpl_err=0 -> bresp=0, bvalid until bready.
REQ-033 Read and write pending in the same cycle after reset -> write issued first, then read; the next simultaneous pair -> read first.
REQ-034 Read addr 0x20 with cpl_rdata=0xDEADBEEF, cpl_err=1 -> rdata=0xDEADBEEF, rresp=2.
REQ-035 bready held low 10 cycles -> bvalid/bresp stable, no req_valid issued; a new AR is accepted (arready) but not issued until after the B handshake.
REQ-036 Reset asserted in WAIT -> next cycle IDLE, all valids 0; a cpl_valid after reset produces no response.
